// File: rtl/sprite_plot_engine.sv
// sprite_plot_engine
//   Pixel writer in front of the 320x240 / 3-bit VGA framebuffer adapter.
//   It owns the player sprite position and turns requests into a stream of
//   single-pixel writes, one per clock:
//     move  : erase the old sprite rectangle with BG_COLOR, then draw the
//             sprite at the new position (STEP pixels in direction dir,
//             clamped to the screen).
//     clear : sweep the whole screen with BG_COLOR, then draw the sprite.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high reset
//   move, dir    move request; dir 00 up, 01 down, 10 left, 11 right
//   clear        full-screen clear plus sprite redraw (wins over move)
//   plot         pixel write strobe (registered)
//   X, Y, color  pixel column / row / colour (registered, hold when plot=0)
//   busy         high in every plot cycle of a sequence
//   pos_x, pos_y current sprite top-left corner
module sprite_plot_engine #(
  parameter int          SCREEN_W     = 320,
  parameter int          SCREEN_H     = 240,
  parameter int          SPRITE_W     = 8,
  parameter int          SPRITE_H     = 8,
  parameter int          STEP         = 4,
  parameter int          INIT_X       = 156,
  parameter int          INIT_Y       = 116,
  parameter logic [2:0]  BG_COLOR     = 3'b000,
  parameter logic [2:0]  SPRITE_COLOR = 3'b110
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move,
  input  logic [1:0] dir,
  input  logic       clear,
  output logic       plot,
  output logic [8:0] X,
  output logic [7:0] Y,
  output logic [2:0] color,
  output logic       busy,
  output logic [8:0] pos_x,
  output logic [7:0] pos_y
);

  typedef enum logic [1:0] {IDLE, CLEAR, ERASE, DRAW} state_t;

  localparam logic [8:0] X_MAX = 9'(SCREEN_W - SPRITE_W);
  localparam logic [7:0] Y_MAX = 8'(SCREEN_H - SPRITE_H);

  state_t     state_reg, state_next;
  // cx/cy always hold the coordinate of the pixel currently on X/Y.
  logic [8:0] cx_reg, cx_next;
  logic [7:0] cy_reg, cy_next;
  logic [8:0] old_x_reg, old_x_next;
  logic [7:0] old_y_reg, old_y_next;
  logic [8:0] pos_x_next;
  logic [7:0] pos_y_next;
  logic       plot_next;
  logic [8:0] x_next;
  logic [7:0] y_next;
  logic [2:0] color_next;

  // Clamped target position for a move; widened sums avoid overflow.
  logic [9:0] sum_x;
  logic [8:0] sum_y;
  logic [8:0] tgt_x;
  logic [7:0] tgt_y;

  always_comb begin
    sum_x = {1'b0, pos_x} + 10'(STEP);
    sum_y = {1'b0, pos_y} + 9'(STEP);
    tgt_x = pos_x;
    tgt_y = pos_y;
    case (dir)
      2'b00: tgt_y = (pos_y < 8'(STEP)) ? 8'd0 : pos_y - 8'(STEP);
      2'b01: tgt_y = (sum_y > {1'b0, Y_MAX}) ? Y_MAX : sum_y[7:0];
      2'b10: tgt_x = (pos_x < 9'(STEP)) ? 9'd0 : pos_x - 9'(STEP);
      default: tgt_x = (sum_x > {1'b0, X_MAX}) ? X_MAX : sum_x[8:0];
    endcase
  end

  // Rectangle bounds depend on whether we sweep the screen or the sprite.
  logic [8:0] last_col;
  logic [7:0] last_row;
  logic       row_end, rect_end;

  always_comb begin
    last_col = (state_reg == CLEAR) ? 9'(SCREEN_W - 1) : 9'(SPRITE_W - 1);
    last_row = (state_reg == CLEAR) ? 8'(SCREEN_H - 1) : 8'(SPRITE_H - 1);
    row_end  = (cx_reg == last_col);
    rect_end = row_end && (cy_reg == last_row);
  end

  // Next-state, counters, position and the pixel to present next cycle.
  always_comb begin
    state_next = state_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    old_x_next = old_x_reg;
    old_y_next = old_y_reg;
    pos_x_next = pos_x;
    pos_y_next = pos_y;

    case (state_reg)
      IDLE: begin
        cx_next = 9'd0;
        cy_next = 8'd0;
        if (clear) begin
          state_next = CLEAR;
        end else if (move && ((tgt_x != pos_x) || (tgt_y != pos_y))) begin
          old_x_next = pos_x;
          old_y_next = pos_y;
          pos_x_next = tgt_x;
          pos_y_next = tgt_y;
          state_next = ERASE;
        end
      end
      default: begin
        if (row_end) begin
          cx_next = 9'd0;
          if (rect_end) begin
            cy_next    = 8'd0;
            state_next = (state_reg == DRAW) ? IDLE : DRAW;
          end else begin
            cy_next = cy_reg + 8'd1;
          end
        end else begin
          cx_next = cx_reg + 9'd1;
        end
      end
    endcase

    plot_next  = (state_next != IDLE);
    x_next     = X;
    y_next     = Y;
    color_next = color;
    case (state_next)
      CLEAR: begin
        x_next     = cx_next;
        y_next     = cy_next;
        color_next = BG_COLOR;
      end
      ERASE: begin
        x_next     = old_x_next + cx_next;
        y_next     = old_y_next + cy_next;
        color_next = BG_COLOR;
      end
      DRAW: begin
        x_next     = pos_x_next + cx_next;
        y_next     = pos_y_next + cy_next;
        color_next = SPRITE_COLOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cx_reg    <= '0;
      cy_reg    <= '0;
      old_x_reg <= '0;
      old_y_reg <= '0;
      pos_x     <= 9'(INIT_X);
      pos_y     <= 8'(INIT_Y);
      plot      <= 1'b0;
      busy      <= 1'b0;
      X         <= '0;
      Y         <= '0;
      color     <= '0;
    end else begin
      state_reg <= state_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      old_x_reg <= old_x_next;
      old_y_reg <= old_y_next;
      pos_x     <= pos_x_next;
      pos_y     <= pos_y_next;
      plot      <= plot_next;
      busy      <= plot_next;
      X         <= x_next;
      Y         <= y_next;
      color     <= color_next;
    end
  end

endmodule
